alu_arbiter: RTL and testbench

Shares one 8-bit ALU between two requesters. Accepts operand/mode requests, grants them round-robin, drives the ALU operands, mode and a start pulse, waits for the ALU `done`, then returns the ALU's three result fields tagged with the requester ID. Sits directly in front of the `ALU` datapath, with one request port per client.

---
 rtl/alu_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ALU between two requesters.
// Requests are granted round-robin in IDLE. The operands and mode are
// registered toward the ALU, a one-cycle start pulse is issued, and the ALU
// results are passed back bit-exact with the served requester ID.
// Optional build macro: ALU_ARB_TIMEOUT_EN adds a WAIT-state abort counter
// that is limited by TIMEOUT.
//
// Handshake: reqN_valid/reqN_ready follow valid/ready rules. A requester
// raises valid and holds valid and its data stable until it sees ready. The
// transfer happens on the cycle where both are high. Ready is combinational
// and is only asserted in IDLE. A valid dropped before ready is not served.
// rsp_valid and alu_start are single-cycle pulses with no back-pressure.

module alu_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [2:0]  req0_mode,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [2:0]  req1_mode,
  output logic        req1_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_mode,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [7:0]  alu_op1,
  input  logic [7:0]  alu_op2,
  input  logic [15:0] alu_op3,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_op1,
  output logic [7:0]  rsp_op2,
  output logic [15:0] rsp_op3,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_id_q, last_id_d;
  logic        cur_id_q, cur_id_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [2:0]  alu_mode_q, alu_mode_d;
  logic        rsp_id_q, rsp_id_d;
  logic [7:0]  rsp_op1_q, rsp_op1_d;
  logic [7:0]  rsp_op2_q, rsp_op2_d;
  logic [15:0] rsp_op3_q, rsp_op3_d;

  logic        grant_valid;
  logic        grant_id;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);
  logic [7:0]  cnt_q, cnt_d;
  logic        rsp_err_q, rsp_err_d;
`else
  // TIMEOUT only matters when the abort counter is built.
  logic [7:0]  unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
`endif

  // Round-robin pick: on a tie, serve the requester that was not served last.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_id_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Next-state logic and datapath captures for the four-state sequencer.
  always_comb begin
    state_d    = state_q;
    last_id_d  = last_id_q;
    cur_id_d   = cur_id_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_mode_d = alu_mode_q;
    rsp_id_d   = rsp_id_q;
    rsp_op1_d  = rsp_op1_q;
    rsp_op2_d  = rsp_op2_q;
    rsp_op3_d  = rsp_op3_q;
`ifdef ALU_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          cur_id_d   = grant_id;
          alu_a_d    = grant_id ? req1_a    : req0_a;
          alu_b_d    = grant_id ? req1_b    : req0_b;
          alu_mode_d = grant_id ? req1_mode : req0_mode;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
`ifdef ALU_ARB_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        // A done level left over from earlier states is only looked at here.
        if (alu_done) begin
          rsp_id_d  = cur_id_q;
          rsp_op1_d = alu_op1;
          rsp_op2_d = alu_op2;
          rsp_op3_d = alu_op3;
`ifdef ALU_ARB_TIMEOUT_EN
          rsp_err_d = 1'b0;
`endif
          state_d   = RESP;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LIMIT) begin
          rsp_id_d  = cur_id_q;
          rsp_op1_d = 8'd0;
          rsp_op2_d = 8'd0;
          rsp_op3_d = 16'd0;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      RESP: begin
        last_id_d = cur_id_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_id_q  <= 1'b1;
      cur_id_q   <= 1'b0;
      alu_a_q    <= 8'd0;
      alu_b_q    <= 8'd0;
      alu_mode_q <= 3'd0;
      rsp_id_q   <= 1'b0;
      rsp_op1_q  <= 8'd0;
      rsp_op2_q  <= 8'd0;
      rsp_op3_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      last_id_q  <= last_id_d;
      cur_id_q   <= cur_id_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_mode_q <= alu_mode_d;
      rsp_id_q   <= rsp_id_d;
      rsp_op1_q  <= rsp_op1_d;
      rsp_op2_q  <= rsp_op2_d;
      rsp_op3_q  <= rsp_op3_d;
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  // WAIT-state abort counter and its error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 8'd0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Decoded handshake pulses and output wiring.
  always_comb begin
    req0_ready = (state_q == IDLE) && grant_valid && !grant_id;
    req1_ready = (state_q == IDLE) && grant_valid &&  grant_id;
    alu_start  = (state_q == ISSUE);
    rsp_valid  = (state_q == RESP);
    busy       = (state_q != IDLE);
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_mode = alu_mode_q;
  assign rsp_id   = rsp_id_q;
  assign rsp_op1  = rsp_op1_q;
  assign rsp_op2  = rsp_op2_q;
  assign rsp_op3  = rsp_op3_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. Define ALU_ARB_TIMEOUT_EN to also
// exercise the timeout abort path with TIMEOUT=8.

module tb_alu_arbiter;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 64;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_mode, req1_mode;
  logic        req0_ready, req1_ready;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_mode;
  logic        alu_start;
  logic        alu_done;
  logic [7:0]  alu_op1, alu_op2;
  logic [15:0] alu_op3;
  logic        rsp_valid, rsp_id, rsp_err, busy;
  logic [7:0]  rsp_op1, rsp_op2;
  logic [15:0] rsp_op3;

  int n_total = 0;
  int n_pass  = 0;

  alu_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req0_mode(req0_mode), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req1_mode(req1_mode), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_start(alu_start),
    .alu_done(alu_done), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op3(alu_op3),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_op1(rsp_op1), .rsp_op2(rsp_op2),
    .rsp_op3(rsp_op3), .rsp_err(rsp_err), .busy(busy)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_start"},  alu_start, 0);
    check({tag, "_rvalid"}, rsp_valid, 0);
    check({tag, "_ready"},  {req1_ready, req0_ready}, 0);
    check({tag, "_alu"},    {alu_mode, alu_b, alu_a}, 0);
    check({tag, "_rsp"},    {rsp_err, rsp_id, rsp_op1, rsp_op2}, 0);
    check({tag, "_op3"},    rsp_op3, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
  endtask

  // Serve one request with done in the first WAIT cycle. Called in IDLE
  // with the requester's valid and data already driven.
  task automatic serve(input logic id, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] m, input logic [7:0] o1,
                       input logic [7:0] o2, input logic [15:0] o3);
    #1;
    check("grant_ready", id ? req1_ready : req0_ready, 1);
    check("other_ready", id ? req0_ready : req1_ready, 0);
    check("idle_busy", busy, 0);
    tick();
    check("issue_start", alu_start, 1);
    check("issue_operands", {alu_mode, alu_b, alu_a}, {m, b, a});
    check("issue_no_ready", {req1_ready, req0_ready}, 0);
    tick();
    check("wait_start_low", alu_start, 0);
    alu_done = 1'b1; alu_op1 = o1; alu_op2 = o2; alu_op3 = o3;
    #1;
    check("wait_no_rsp", rsp_valid, 0);
    tick();
    alu_done = 1'b0;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id", rsp_id, id);
    check("rsp_ops", {rsp_op1, rsp_op2}, {o1, o2});
    check("rsp_op3", rsp_op3, o3);
    check("rsp_err", rsp_err, 0);
    check("rsp_operands_stable", {alu_mode, alu_b, alu_a}, {m, b, a});
    tick();
    check("rsp_pulse_end", rsp_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_mode = 0;
    req1_a = 0; req1_b = 0; req1_mode = 0;
    alu_done = 0; alu_op1 = 0; alu_op2 = 0; alu_op3 = 0;
    #2;
    check_reset_outputs("por");
    do_reset();

    // Single request, ALU done 4 cycles after start.
    req0_valid = 1; req0_a = 8'd3; req0_b = 8'd2; req0_mode = 3'b100;
    #1;
    check("t1_ready", req0_ready, 1);
    tick();                                   // T+1
    req0_valid = 0;
    check("t1_start", alu_start, 1);
    check("t1_operands", {alu_mode, alu_b, alu_a}, {3'b100, 8'd2, 8'd3});
    tick(); tick(); tick();                   // T+4
    check("t1_wait_busy", busy, 1);
    tick();                                   // T+5
    alu_done = 1; alu_op1 = 8'd5; alu_op2 = 8'd1; alu_op3 = 16'd6;
    #1;
    check("t1_no_rsp_yet", rsp_valid, 0);
    tick();                                   // T+6
    alu_done = 0;
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_id", rsp_id, 0);
    check("t1_rsp_op3", rsp_op3, 16'd6);
    check("t1_rsp_ops", {rsp_op1, rsp_op2}, {8'd5, 8'd1});
    check("t1_rsp_err", rsp_err, 0);
    tick();
    check("t1_rsp_end", rsp_valid, 0);
    check("t1_rsp_hold", rsp_op3, 16'd6);
    check("t1_idle", busy, 0);

    // Both requesters continuously valid from reset: grants alternate.
    do_reset();
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      req0_a = 8'(k + 1); req0_b = 8'(k + 16); req0_mode = 3'(k);
      serve(1'b0, 8'(k + 1), 8'(k + 16), 3'(k), 8'(k * 3), 8'(k + 100), 16'hA000 + 16'(k));
      req1_a = 8'(k + 40); req1_b = 8'(k + 80); req1_mode = 3'(7 - k);
      serve(1'b1, 8'(k + 40), 8'(k + 80), 3'(7 - k), 8'(k + 200), 8'(k * 5), 16'h5A00 + 16'(k));
    end
    req0_valid = 0; req1_valid = 0;
    tick();

    // req1 arrives while req0 is in flight; it waits for IDLE.
    req0_valid = 1; req0_a = 8'h11; req0_b = 8'h22; req0_mode = 3'd1;
    #1;
    check("t3_req0_ready", req0_ready, 1);
    tick();                                   // ISSUE
    req0_valid = 0;
    req1_valid = 1; req1_a = 8'h33; req1_b = 8'h44; req1_mode = 3'd2;
    #1;
    check("t3_issue_r1_blocked", req1_ready, 0);
    tick();                                   // WAIT
    check("t3_wait_r1_blocked", req1_ready, 0);
    tick();                                   // WAIT
    check("t3_wait2_r1_blocked", req1_ready, 0);
    alu_done = 1; alu_op1 = 8'h01; alu_op2 = 8'h02; alu_op3 = 16'h0304;
    tick();                                   // RESP
    alu_done = 0;
    check("t3_resp_r1_blocked", req1_ready, 0);
    check("t3_resp_id", {rsp_valid, rsp_id}, 2'b10);
    tick();                                   // IDLE
    serve(1'b1, 8'h33, 8'h44, 3'd2, 8'hC1, 8'hC2, 16'hC3C4);
    req1_valid = 0;

    // Reset pulse while in WAIT, followed by a stray done.
    req0_valid = 1; req0_a = 8'h99; req0_b = 8'h88; req0_mode = 3'd5;
    tick();                                   // ISSUE
    req0_valid = 0;
    tick();                                   // WAIT
    check("t4_in_wait", busy, 1);
    rst = 1;
    #1;
    check_reset_outputs("t4_async");
    #2;
    rst = 0;
    tick();
    alu_done = 1; alu_op1 = 8'hEE; alu_op2 = 8'hDD; alu_op3 = 16'hBEEF;
    tick();
    alu_done = 0;
    check("t4_stray_no_rsp", rsp_valid, 0);
    check("t4_stray_idle", busy, 0);
    check("t4_stray_op3", rsp_op3, 0);
    tick();
    check("t4_stray_no_rsp2", rsp_valid, 0);
    req0_valid = 1; req0_a = 8'h07; req0_b = 8'h08; req0_mode = 3'd6;
    serve(1'b0, 8'h07, 8'h08, 3'd6, 8'h70, 8'h80, 16'h7080);
    req0_valid = 0;

    // done held high from before ISSUE: response only at T+3.
    alu_done = 1; alu_op1 = 8'h5A; alu_op2 = 8'hA5; alu_op3 = 16'h1234;
    req1_valid = 1; req1_a = 8'h21; req1_b = 8'h12; req1_mode = 3'd3;
    #1;
    check("t6_ready", req1_ready, 1);
    tick();                                   // T+1 ISSUE
    req1_valid = 0;
    check("t6_issue_no_rsp", rsp_valid, 0);
    check("t6_issue_start", alu_start, 1);
    tick();                                   // T+2 WAIT
    check("t6_wait_no_rsp", rsp_valid, 0);
    tick();                                   // T+3 RESP
    alu_done = 0;
    check("t6_rsp_valid", rsp_valid, 1);
    check("t6_rsp", {rsp_id, rsp_op1, rsp_op2}, {1'b1, 8'h5A, 8'hA5});
    check("t6_rsp_op3", rsp_op3, 16'h1234);
    tick();

`ifdef ALU_ARB_TIMEOUT_EN
    // ALU never answers: abort after TIMEOUT WAIT cycles.
    req0_valid = 1; req0_a = 8'h44; req0_b = 8'h55; req0_mode = 3'd7;
    tick();                                   // T+1 ISSUE
    req0_valid = 0;
    tick();                                   // T+2 first WAIT
    check("to_wait_first", rsp_valid, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_wait_no_rsp", rsp_valid, 0);
    end
    tick();                                   // T+10 RESP
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_id", rsp_id, 0);
    check("to_rsp_zero", {rsp_op1, rsp_op2, rsp_op3}, 0);
    tick();
    req1_valid = 1; req1_a = 8'h0A; req1_b = 8'h0B; req1_mode = 3'd4;
    serve(1'b1, 8'h0A, 8'h0B, 3'd4, 8'hAA, 8'hBB, 16'hABCD);
    req1_valid = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
